// File: rtl/qar_mem_arbiter_pkg.sv
// qar_mem_arbiter_pkg
// Shared state and grant encodings for the fetch/data memory arbiter.
package qar_mem_arbiter_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_I = 2'd1,
        ARB_LOCK_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } arb_gnt_e;

    // Lock state entered when a grant does not complete in its first cycle
    function automatic arb_state_e lock_state_of(input arb_gnt_e gnt);
        arb_state_e st;
        case (gnt)
            GNT_I:   st = ARB_LOCK_I;
            GNT_D:   st = ARB_LOCK_D;
            default: st = ARB_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/qar_mem_arbiter_if.sv
// qar_mem_arbiter_if
// Bundles the core fetch bus (imem_*), core data bus (mem_*) and the single
// downstream port (m_*). The 'master' modport is the arbiter's view (it masters
// the downstream port); 'slave' is the environment's view (core + fabric).
interface qar_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_valid;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ready;
    logic [DATA_WIDTH-1:0] imem_rdata;

    logic                  mem_valid;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  m_valid;
    logic                  m_we;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_rdata;

    modport master (
        input  imem_valid, imem_addr,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        input  m_ready, m_rdata,
        output imem_ready, imem_rdata,
        output mem_ready, mem_rdata,
        output m_valid, m_we, m_addr, m_wdata
    );

    modport slave (
        output imem_valid, imem_addr,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        output m_ready, m_rdata,
        input  imem_ready, imem_rdata,
        input  mem_ready, mem_rdata,
        input  m_valid, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/qar_mem_arbiter_starve_ctr.sv
// qar_arb_starve_ctr
// 4-bit saturating count of data grants taken while a fetch is waiting.
// sat flags that the fetch must win the next arbitration.
module qar_arb_starve_ctr
    import qar_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [STARVE_W-1:0] MAX_WAIT_C = STARVE_W'(MAX_WAIT);

    logic [STARVE_W-1:0] cnt_r;

    // Count data completions, clear wins over increment, hold at MAX_WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {STARVE_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {STARVE_W{1'b0}};
        end else if (inc && !sat) begin
            cnt_r <= cnt_r + {{(STARVE_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat = (cnt_r == MAX_WAIT_C);

endmodule

// File: rtl/qar_mem_arbiter.sv
// qar_mem_arbiter
// Shares one memory port between the core's fetch and data buses. Data has
// fixed priority; after MAX_WAIT consecutive data grants with a fetch pending,
// the fetch is forced through. A grant that does not complete in its first
// cycle is locked until m_ready. The downstream request is combinational from
// the granted requester so a zero-wait memory adds no latency.
// Optional build macro: QAR_ARB_STATS_EN adds transfer/stall counters.
module qar_mem_arbiter
    import qar_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    qar_mem_arbiter_if.master      bus,
    output logic                   proto_err
`ifdef QAR_ARB_STATS_EN
    ,
    output logic [15:0]            stat_fetch_cnt,
    output logic [15:0]            stat_data_cnt,
    output logic [15:0]            stat_stall_cnt
`endif
);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    arb_gnt_e   gnt_s;
    logic       drop_s;
    logic       proto_err_r;
    logic       starve_sat_s;
    logic       fetch_done_s;
    logic       data_done_s;

    // Grant selection and next state; reset forces no grant so m_valid drops at once
    always_comb begin
        gnt_s       = GNT_NONE;
        state_nxt_s = state_r;
        drop_s      = 1'b0;
        if (!rst_n) begin
            gnt_s       = GNT_NONE;
            state_nxt_s = ARB_IDLE;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (bus.imem_valid && (starve_sat_s || !bus.mem_valid)) begin
                        gnt_s = GNT_I;
                    end else if (bus.mem_valid) begin
                        gnt_s = GNT_D;
                    end else begin
                        gnt_s = GNT_NONE;
                    end
                end
                ARB_LOCK_I: begin
                    if (bus.imem_valid) begin
                        gnt_s = GNT_I;
                    end else begin
                        gnt_s  = GNT_NONE;
                        drop_s = 1'b1;
                    end
                end
                ARB_LOCK_D: begin
                    if (bus.mem_valid) begin
                        gnt_s = GNT_D;
                    end else begin
                        gnt_s  = GNT_NONE;
                        drop_s = 1'b1;
                    end
                end
                default: begin
                    gnt_s = GNT_NONE;
                end
            endcase

            if (gnt_s == GNT_NONE) begin
                state_nxt_s = ARB_IDLE;
            end else if (bus.m_ready) begin
                state_nxt_s = ARB_IDLE;
            end else begin
                state_nxt_s = lock_state_of(gnt_s);
            end
        end
    end

    // Downstream request and completion routing for the granted requester
    always_comb begin
        bus.m_valid    = 1'b0;
        bus.m_we       = 1'b0;
        bus.m_addr     = {ADDR_WIDTH{1'b0}};
        bus.m_wdata    = {DATA_WIDTH{1'b0}};
        bus.imem_ready = 1'b0;
        bus.imem_rdata = {DATA_WIDTH{1'b0}};
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = {DATA_WIDTH{1'b0}};
        case (gnt_s)
            GNT_I: begin
                bus.m_valid    = 1'b1;
                bus.m_addr     = bus.imem_addr;
                bus.imem_ready = bus.m_ready;
                bus.imem_rdata = bus.m_ready ? bus.m_rdata : {DATA_WIDTH{1'b0}};
            end
            GNT_D: begin
                bus.m_valid   = 1'b1;
                bus.m_we      = bus.mem_we;
                bus.m_addr    = bus.mem_addr;
                bus.m_wdata   = bus.mem_wdata;
                bus.mem_ready = bus.m_ready;
                bus.mem_rdata = bus.m_ready ? bus.m_rdata : {DATA_WIDTH{1'b0}};
            end
            default: begin
                bus.m_valid = 1'b0;
            end
        endcase
    end

    assign fetch_done_s = (gnt_s == GNT_I) && bus.m_ready;
    assign data_done_s  = (gnt_s == GNT_D) && bus.m_ready;

    qar_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (data_done_s && bus.imem_valid),
        .clr   (fetch_done_s || !bus.imem_valid),
        .sat   (starve_sat_s)
    );

    // Arbitration state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sticky flag for a locked requester abandoning its request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_r <= 1'b0;
        end else if (drop_s) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    assign proto_err = proto_err_r;

`ifdef QAR_ARB_STATS_EN
    logic [15:0] fetch_cnt_r;
    logic [15:0] data_cnt_r;
    logic [15:0] stall_cnt_r;
    logic        stall_s;

    assign stall_s = (bus.imem_valid && !bus.imem_ready) ||
                     (bus.mem_valid && !bus.mem_ready);

    // Wrapping counts of completed transfers and stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_r <= 16'd0;
            data_cnt_r  <= 16'd0;
            stall_cnt_r <= 16'd0;
        end else begin
            fetch_cnt_r <= fetch_done_s ? fetch_cnt_r + 16'd1 : fetch_cnt_r;
            data_cnt_r  <= data_done_s  ? data_cnt_r  + 16'd1 : data_cnt_r;
            stall_cnt_r <= stall_s      ? stall_cnt_r + 16'd1 : stall_cnt_r;
        end
    end

    assign stat_fetch_cnt = fetch_cnt_r;
    assign stat_data_cnt  = data_cnt_r;
    assign stat_stall_cnt = stall_cnt_r;
`endif

endmodule
